// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding, digit width and
// the largest legal BCD digit value.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit <= BCD_MAX) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Combinational single-digit BCD adder cell: binary add, then +6 correction whenever
// the raw sum leaves the decimal range.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] A,
  input  logic [BCD_DIGIT_W-1:0] B,
  input  logic                   Cin,
  output logic [BCD_DIGIT_W-1:0] Sum,
  output logic                   Cout
);

  logic [BCD_DIGIT_W:0] raw_s;
  logic [BCD_DIGIT_W:0] adj_s;

  assign raw_s = {1'b0, A} + {1'b0, B} + {4'd0, Cin};
  assign adj_s = raw_s + 5'd6;

  // Decimal correction of the binary sum.
  always_comb begin
    Sum  = raw_s[BCD_DIGIT_W-1:0];
    Cout = 1'b0;
    if (raw_s > 5'd9) begin
      Sum  = adj_s[BCD_DIGIT_W-1:0];
      Cout = 1'b1;
    end else begin
      Sum  = raw_s[BCD_DIGIT_W-1:0];
      Cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit pair per clock, LSD first.
// Optional build macro BCD_INVALID_CHECK_EN enables the sticky invalid-digit flag on err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] A,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] B,
  input  logic                           Cin,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_DIGIT_W*NDIGITS-1:0] Sum,
  output logic                           Cout,
  output logic                           err
);

  localparam int W     = BCD_DIGIT_W * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   carry_r;
  logic [W-1:0]           a_r;
  logic [W-1:0]           b_r;
  logic [W-1:0]           sum_r;
  logic                   cout_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;

  logic                   cnt_last_s;
  logic                   accept_s;
  logic                   step_s;
  logic                   last_s;
  logic [BCD_DIGIT_W-1:0] a_dig_s;
  logic [BCD_DIGIT_W-1:0] b_dig_s;
  logic [BCD_DIGIT_W-1:0] cell_sum_s;
  logic                   cell_cout_s;

  assign cnt_last_s = (cnt_r == CNT_W'(NDIGITS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_last_s) state_s = ST_IDLE;
        else            state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM control decode for the datapath.
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        accept_s = start;
      end
      ST_RUN: begin
        step_s = 1'b1;
        last_s = cnt_last_s;
      end
      default: begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        last_s   = 1'b0;
      end
    endcase
  end

  // Select the current digit pair from the latched operands.
  always_comb begin
    a_dig_s = '0;
    b_dig_s = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        a_dig_s = a_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        b_dig_s = b_r[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end else begin
        a_dig_s = a_dig_s;
        b_dig_s = b_dig_s;
      end
    end
  end

  bcd_adder u_cell (
    .A    (a_dig_s),
    .B    (b_dig_s),
    .Cin  (carry_r),
    .Sum  (cell_sum_s),
    .Cout (cell_cout_s)
  );

  // Operand latch, digit counter, ripple carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= A;
      b_r     <= B;
      cnt_r   <= '0;
      carry_r <= Cin;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (step_s) begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (cnt_r == CNT_W'(i)) begin
          sum_r[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= cell_sum_s;
        end
      end
      carry_r <= cell_cout_s;
      if (last_s) begin
        cnt_r  <= '0;
        cout_r <= cell_cout_s;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  // Sticky invalid-digit flag, cleared when a new operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= 1'b0;
    end else if (step_s && (!bcd_digit_ok(a_dig_s) || !bcd_digit_ok(b_dig_s))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  // Invalid-digit checking is compiled out; the flag stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
    end
  end
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign Sum  = sum_r;
  assign Cout = cout_r;
  assign err  = err_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed cases plus random BCD operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int ND  = 4;
  localparam int W   = 4 * ND;
  localparam int MOD = 10 ** ND;
`ifdef BCD_INVALID_CHECK_EN
  localparam logic INV_ERR = 1'b1;
`else
  localparam logic INV_ERR = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         Cin   = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.NDIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Drive a request (caller is away from the rising edge); scramble inputs after accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
  endtask

  // Wait for done, checking latency, busy duration and the result against the model.
  task automatic collect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit chk_sum, input bit poke, input logic exp_err);
    int lat = -1;
    int busy_n = 0;
    int tot = bcd2int(a) + bcd2int(b) + int'(cin);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (busy) busy_n++;
      if (poke && i == 1) begin
        start = 1'b1; A = rand_bcd(); B = rand_bcd(); Cin = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, ND);
    check({tag, "_busy_cycles"}, busy_n, ND);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (chk_sum) begin
      check({tag, "_sum"}, 32'(Sum), 32'(int2bcd(tot % MOD)));
      check({tag, "_cout"}, 32'(Cout), (tot >= MOD) ? 32'd1 : 32'd0);
    end
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  // done must drop after one cycle while Sum is held.
  task automatic pulse_gap(input string tag, input logic [W-1:0] exp_sum);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(Sum), 32'(exp_sum));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           extra_done;

    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_cout", 32'(Cout), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h1234, 16'h5678, 1'b0);
    collect("t1", 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t1_sum_direct", 32'(Sum), 32'h6912);
    pulse_gap("t1", 16'h6912);

    issue(16'h9999, 16'h0001, 1'b0);
    collect("t2", 16'h9999, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_gap("t2", 16'h0000);

    issue(16'h9999, 16'h9999, 1'b1);
    collect("t3a", 16'h9999, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(16'h0000, 16'h0000, 1'b0);
    collect("t3b", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_gap("t3b", 16'h0000);

    issue(16'h4321, 16'h1111, 1'b0);
    collect("t4", 16'h4321, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("t4_single_done", extra_done, 0);

    issue(16'h1234, 16'h5678, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_sum", 32'(Sum), 32'd0);
    check("t5_rst_cout", 32'(Cout), 32'd0);
    check("t5_rst_err", 32'(err), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("t5_no_done", extra_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'h1234, 16'h5678, 1'b0);
    collect("t5", 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_sum_direct", 32'(Sum), 32'h6912);
    pulse_gap("t5", 16'h6912);

    issue(16'h00A0, 16'h0001, 1'b0);
    collect("t6a", 16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b0, INV_ERR);
    pulse_gap("t6a", Sum);
    issue(16'h0505, 16'h0505, 1'b0);
    collect("t6b", 16'h0505, 16'h0505, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_gap("t6b", 16'h1010);

    for (int k = 0; k < 20; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom);
      issue(ra, rb, rc);
      collect($sformatf("rnd%0d", k), ra, rb, rc, 1'b1, 1'b0, 1'b0);
      if (k % 2 == 0) pulse_gap($sformatf("rnd%0d", k), Sum);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
